// File: rtl/fifo_wr_arbiter_if.sv
// Handshake and FIFO write bundle shared by the requesters, the write arbiter and the FIFO.
// slave: arbiter view; master: requester/FIFO environment view.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_data;
    logic [ID_WIDTH-1:0]           fifo_wr_id;
    logic                          locked;

    modport slave (
        input  req_valid, req_last, req_data, fifo_full,
        output req_ready, fifo_wr_en, fifo_data, fifo_wr_id, locked
    );

    modport master (
        output req_valid, req_last, req_data, fifo_full,
        input  req_ready, fifo_wr_en, fifo_data, fifo_wr_id, locked
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers, zero-cycle grant.
// Define ARB_LOCK_EN to add the burst-lock FSM (req_last, MAX_BURST forced release, locked).
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input logic              clk,
    input logic              rst_n,
    fifo_wr_arbiter_if.slave bus
);

    logic [ID_WIDTH-1:0]           ptr_q, ptr_d;
    logic [ID_WIDTH-1:0]           rr_win;
    logic [ID_WIDTH-1:0]           win;
    logic [ID_WIDTH-1:0]           win_nxt;
    logic                          rr_vld;
    logic                          win_vld;
    logic                          xfer;
    logic [2*NUM_REQ-1:0]          vld_rot;
    logic [NUM_REQ-1:0]            vld_sh;
    logic [NUM_REQ*DATA_WIDTH-1:0] data_sh;
    int                            rr_idx;

    // Rotate valids so bit k corresponds to requester ptr+k; first set bit wins.
    always_comb begin
        rr_vld  = 1'b0;
        rr_win  = '0;
        rr_idx  = 0;
        vld_rot = {bus.req_valid, bus.req_valid} >> ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!rr_vld && vld_rot[k]) begin
                rr_vld = 1'b1;
                rr_idx = int'(ptr_q) + k;
                if (rr_idx >= NUM_REQ) rr_idx = rr_idx - NUM_REQ;
                rr_win = ID_WIDTH'(rr_idx);
            end
        end
    end

`ifdef ARB_LOCK_EN
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_LOCK = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [ID_WIDTH-1:0] own_q, own_d;
    logic [7:0]          beat_q, beat_d;
    logic [NUM_REQ-1:0]  last_sh;

    // While locked only the owner may be served; an idle owner leaves a bubble.
    assign win = (state_q == S_LOCK) ? own_q : rr_win;
`else
    logic unused_last;

    assign unused_last = ^bus.req_last;
    assign win         = rr_win;
`endif

    assign win_nxt = (int'(win) + 1 >= NUM_REQ) ? '0 : win + ID_WIDTH'(1);

    always_comb begin
        vld_sh  = bus.req_valid >> win;
        win_vld = vld_sh[0];
        data_sh = bus.req_data >> (int'(win) * DATA_WIDTH);
        xfer    = rst_n && win_vld && !bus.fifo_full;

        bus.req_ready  = xfer ? (NUM_REQ'(1) << win) : '0;
        bus.fifo_wr_en = xfer;
        bus.fifo_data  = xfer ? data_sh[DATA_WIDTH-1:0] : '0;
        bus.fifo_wr_id = xfer ? win : '0;
    end

`ifdef ARB_LOCK_EN
    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        beat_d  = beat_q;
        ptr_d   = ptr_q;
        last_sh = bus.req_last >> win;
        if (xfer) begin
            if (state_q == S_IDLE) begin
                if (!last_sh[0] && MAX_BURST > 1) begin
                    state_d = S_LOCK;
                    own_d   = win;
                    beat_d  = 8'd1;
                end else begin
                    ptr_d = win_nxt;
                end
            end else if (!last_sh[0] && (int'(beat_q) + 1 < MAX_BURST)) begin
                beat_d = beat_q + 8'd1;
            end else begin
                // Release on last beat or when the burst hits MAX_BURST.
                state_d = S_IDLE;
                beat_d  = 8'd0;
                ptr_d   = win_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            own_q   <= '0;
            beat_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            beat_q  <= beat_d;
        end
    end

    assign bus.locked = rst_n && (state_q == S_LOCK);
`else
    assign ptr_d      = xfer ? win_nxt : ptr_q;
    assign bus.locked = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a behavioural FIFO occupancy model driving fifo_full.
// Burst-lock steps are compiled in when ARB_LOCK_EN is defined.
module tb_fifo_wr_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int ID_WIDTH   = 2;
    localparam int DATA_WIDTH = 8;
    localparam int MAX_BURST  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   fails = 0;

    int   cnt = 0;
    int   depth = 1000;
    logic force_full = 1'b0;
    logic clr = 1'b0;

    fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH), .DATA_WIDTH(DATA_WIDTH), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (clr)                 cnt <= 0;
        else if (bus.fifo_wr_en) cnt <= cnt + 1;
    end

    assign bus.fifo_full = force_full || (cnt >= depth);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [7:0] d);
        bus.req_data[i*DATA_WIDTH +: DATA_WIDTH] = d;
    endtask

    task automatic chk_wr(input string tag, input logic [ID_WIDTH-1:0] id, input logic [7:0] d);
        chk({tag, "_en"}, bus.fifo_wr_en, 1);
        chk({tag, "_id"}, bus.fifo_wr_id, id);
        chk({tag, "_data"}, bus.fifo_data, d);
    endtask

    initial begin
        int k;
        bus.req_valid = 4'b1111;
        bus.req_last  = 4'b1111;
        bus.req_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) set_data(i, 8'h10 + 8'(i));

        // Reset forces outputs low even with every requester valid
        #2;
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_wr_en", bus.fifo_wr_en, 0);
        chk("rst_data", bus.fifo_data, 0);
        chk("rst_locked", bus.locked, 0);
        step();
        step();
        bus.req_valid = 4'b0000;
        rst_n = 1'b1;
        #1;
        chk("idle_wr_en", bus.fifo_wr_en, 0);
        chk("idle_ready", bus.req_ready, 0);
        step();

        // Continuous round robin across all four requesters
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk_wr("rr", 2'(c % 4), 8'h10 + 8'(c % 4));
            chk("rr_ready", bus.req_ready, 32'(1) << (c % 4));
            step();
        end

        // FIFO full stalls without moving the pointer
        bus.req_valid = 4'b1010;
        set_data(1, 8'hA1);
        set_data(3, 8'hA3);
        force_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("full_wr_en", bus.fifo_wr_en, 0);
            chk("full_ready", bus.req_ready, 0);
            step();
        end
        force_full = 1'b0;
        #1;
        chk_wr("after_full1", 2'd1, 8'hA1);
        step();
        bus.req_valid = 4'b1000;
        #1;
        chk_wr("after_full3", 2'd3, 8'hA3);
        step();
        bus.req_valid = 4'b0000;

        // Requester 0 pushes 20 beats into an empty 16-deep FIFO
        clr = 1'b1;
        step();
        clr = 1'b0;
        depth = 16;
        k = 0;
        set_data(0, 8'(k));
        bus.req_valid = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            #1;
            chk("fill_wr_en", bus.fifo_wr_en, (c < 16) ? 1 : 0);
            chk("fill_ready", bus.req_ready, (c < 16) ? 1 : 0);
            if (c < 16) begin
                chk("fill_data", bus.fifo_data, k);
                k++;
            end
            step();
            set_data(0, 8'(k));
        end
        chk("fill_count", cnt, 16);
        bus.req_valid = 4'b0000;
        clr = 1'b1;
        step();
        clr = 1'b0;
        depth = 1000;

        // Pointer is at 1: requesters 0 and 2 valid -> 2 wins
        bus.req_valid = 4'b0101;
        set_data(0, 8'h50);
        set_data(2, 8'h52);
        #1;
        chk_wr("skip", 2'd2, 8'h52);
        step();

        // Pointer at 3: full set valid serves 3 then 0; reset mid-run returns pointer to 0
        bus.req_valid = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) set_data(i, 8'h10 + 8'(i));
        #1;
        chk_wr("pre_rst3", 2'd3, 8'h13);
        step();
        #1;
        chk_wr("pre_rst0", 2'd0, 8'h10);
        step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_en", bus.fifo_wr_en, 0);
        chk("mid_rst_ready", bus.req_ready, 0);
        chk("mid_rst_id", bus.fifo_wr_id, 0);
        step();
        rst_n = 1'b1;
        #1;
        chk_wr("post_rst", 2'd0, 8'h10);
        step();

`ifdef ARB_LOCK_EN
        // Pointer at 1: one single beat from requester 1 moves it to 2
        bus.req_valid = 4'b0010;
        #1;
        chk_wr("lk_prep", 2'd1, 8'h11);
        step();

        // Requester 2 bursts 3 beats while requester 0 waits
        bus.req_valid = 4'b0101;
        bus.req_last  = 4'b1011;
        for (int c = 0; c < 3; c++) begin
            set_data(2, 8'h20 + 8'(c));
            if (c == 2) bus.req_last = 4'b1111;
            #1;
            chk_wr("lkA", 2'd2, 8'h20 + 8'(c));
            chk("lkA_locked", bus.locked, (c > 0) ? 1 : 0);
            step();
        end
        bus.req_valid = 4'b0001;
        #1;
        chk_wr("lkA_next", 2'd0, 8'h10);
        chk("lkA_unlocked", bus.locked, 0);
        step();

        // Requester 1 streams without last: forced release after MAX_BURST beats
        bus.req_valid = 4'b1010;
        bus.req_last  = 4'b1101;
        for (int c = 0; c < 4; c++) begin
            set_data(1, 8'hB0 + 8'(c));
            #1;
            chk_wr("lkB", 2'd1, 8'hB0 + 8'(c));
            chk("lkB_locked", bus.locked, (c > 0) ? 1 : 0);
            step();
        end
        set_data(1, 8'hB4);
        #1;
        chk_wr("lkB_release", 2'd3, 8'h13);
        chk("lkB_unlocked", bus.locked, 0);
        step();

        // Restart a burst from requester 1, then reset it away mid-burst
        bus.req_valid = 4'b0010;
        #1;
        chk_wr("lkC1", 2'd1, 8'hB4);
        step();
        set_data(1, 8'hB5);
        #1;
        chk("lkC_locked", bus.locked, 1);
        step();
        rst_n = 1'b0;
        #1;
        chk("lkC_rst_locked", bus.locked, 0);
        chk("lkC_rst_wr_en", bus.fifo_wr_en, 0);
        step();
        rst_n = 1'b1;
        bus.req_valid = 4'b0011;
        #1;
        chk_wr("lkC_post", 2'd0, 8'h10);
        chk("lkC_post_locked", bus.locked, 0);
        step();
`endif

        bus.req_valid = 4'b0000;
        step();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
